ehgu_fifo_arb: RTL and testbench
================================

EHGU_FIFO_ARB -- requirements
Module: ehgu_fifo_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8: data width per beat.
REQ-003 Parameter MEM_DEPTH, default 128: FIFO capacity in entries (power of two); CWIDTH = $clog2(MEM_DEPTH)+1.
REQ-004 One clock, clk0; reset is rstn, synchronous, active-low.
REQ-005 clk0  input  1  sole clock; all state updates on rising edge.
REQ-006 rstn  input  1  synchronous active-low reset.
REQ-007 req_valid  input  NREQ  per-requester beat valid.
REQ-008 req_last  input  NREQ  per-requester last beat of burst.
REQ-009 req_data  input  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
REQ-010 req_ready  output  NREQ  one-hot-or-zero grant, combinational.
REQ-011 pop  input  1  FIFO read side consumed one entry this cycle.
REQ-012 fifo_en  output  1  registered FIFO write enable.
REQ-013 fifo_data  output  WIDTH  registered FIFO write data.
REQ-014 grant_id  output  $clog2(NREQ)  registered index of requester written by fifo_en.
REQ-015 count  output  CWIDTH  FIFO occupancy.
REQ-016 full / empty  output  1 each  count==MEM_DEPTH / count==0.
REQ-017 pop_err  output  1  sticky: pop seen while empty.

Function
REQ-018 Beat accepted on requester i when req_valid[i] && req_ready[i].
REQ-019 req_ready SHALL be all-zero when full; no same-cycle pop bypass.
REQ-020 FSM states IDLE and BURST.
REQ-021 IDLE: grant highest-priority valid requester, round-robin from rr_ptr upward with wrap; accepted beat with req_last=0 -> BURST, locked to winner.
REQ-022 IDLE accept with req_last=1 stays IDLE; rr_ptr <= winner+1 mod NREQ.
REQ-023 BURST: only locked requester may receive ready; others wait regardless of valid.
REQ-024 BURST: locked requester valid low or full -> stall, stay BURST, lock held.
REQ-025 BURST: accepted beat with req_last=1 -> IDLE, rr_ptr <= locked+1 mod NREQ.
REQ-026 Accepted beat SHALL appear on fifo_en/fifo_data/grant_id exactly one cycle later; fifo_en low otherwise, fifo_data holds last value.
REQ-027 count +1 on accept, -1 on pop with count>0, unchanged on both together; updated the cycle after the accept.
REQ-028 pop while count==0: count stays 0, pop_err set, cleared only by reset.
REQ-029 Full limit uses updated count; no more than MEM_DEPTH accepts without pops.

Reset
REQ-030 rstn low at a clock edge: state IDLE, rr_ptr 0, count 0, fifo_en 0, fifo_data 0, grant_id 0, pop_err 0.
REQ-031 While rstn low req_ready SHALL be all-zero; reset mid-burst drops lock with no further beats written.

Structure
REQ-032 Package ehgu_pkg holds state enum (IDLE, BURST) and default NREQ/WIDTH/MEM_DEPTH constants.
REQ-033 One combinational sub-module ehgu_rr_pick (valid vector + rr_ptr -> one-hot winner + index).
REQ-034 Block drives ehgu_fifo write side; clk0 shared with FIFO wclk.

Verification
REQ-035 Reqs 0,1,2,3 valid, single beats (last=1), no pops -> grant order 0,1,2,3,0; grant_id matches one cycle later.
REQ-036 Req1 3-beat burst (last on 3rd), req2 valid throughout -> three consecutive grant_id=1 writes, then 2.
REQ-037 Fill to 128, no pops -> full=1, req_ready=0; one pop -> count 127, next cycle accept allowed.
REQ-038 count=5, accept and pop same cycle -> count 5; pop at count 0 -> pop_err=1, count 0.
REQ-039 rstn low mid-burst (req0 beat 2 of 4) -> next cycle IDLE, count 0, fifo_en 0, rr_ptr 0.
REQ-040 Locked req2 drops valid for 4 cycles while req0 valid -> no grants to req0 until req2 last.

Source files
------------

// File: rtl/ehgu_pkg.sv
// Shared types and default sizing for the ehgu FIFO write-side arbiter.
package ehgu_pkg;

  localparam int unsigned NREQ_DEF      = 4;
  localparam int unsigned WIDTH_DEF     = 8;
  localparam int unsigned MEM_DEPTH_DEF = 128;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/ehgu_rr_pick.sv
// Round-robin picker: first valid requester at or above ptr, wrapping to 0.
module ehgu_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] j;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % int'(NREQ));
      if (valid[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = j;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ehgu_fifo_arb.sv
// Burst-aware round-robin arbiter feeding the write side of an ehgu_fifo,
// with its own occupancy tracking for full/empty and underflow reporting.
module ehgu_fifo_arb
  import ehgu_pkg::*;
#(
  parameter  int unsigned NREQ      = NREQ_DEF,
  parameter  int unsigned WIDTH     = WIDTH_DEF,
  parameter  int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
  localparam int unsigned IW        = $clog2(NREQ),
  localparam int unsigned CWIDTH    = $clog2(MEM_DEPTH) + 1
) (
  input  logic                  clk0,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  pop,
  output logic                  fifo_en,
  output logic [WIDTH-1:0]      fifo_data,
  output logic [IW-1:0]         grant_id,
  output logic [CWIDTH-1:0]     count,
  output logic                  full,
  output logic                  empty,
  output logic                  pop_err
);

  state_t            state, state_next;
  logic [IW-1:0]     lock, lock_next;
  logic [IW-1:0]     rr_ptr, rr_ptr_next;

  logic [NREQ-1:0]   pick_onehot;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;

  logic              accept;
  logic [IW-1:0]     acc_idx;
  logic              acc_last;
  logic [WIDTH-1:0]  acc_data;
  logic [CWIDTH-1:0] count_next;

  ehgu_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .valid  (req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign full  = (count == CWIDTH'(MEM_DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk0) begin
    if (!rstn) begin
      state  <= IDLE;
      lock   <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      lock   <= lock_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  // Grant selection and burst lock; ready is gated by reset and full.
  always_comb begin
    state_next  = state;
    lock_next   = lock;
    rr_ptr_next = rr_ptr;
    req_ready   = '0;
    acc_idx     = lock;
    accept      = 1'b0;
    acc_last    = 1'b0;
    acc_data    = '0;
    case (state)
      IDLE: begin
        acc_idx = pick_idx;
        if (rstn && !full && pick_any) req_ready = pick_onehot;
      end
      BURST: begin
        if (rstn && !full && req_valid[lock]) req_ready[lock] = 1'b1;
      end
      default: ;
    endcase
    accept   = |(req_valid & req_ready);
    acc_last = req_last[acc_idx];
    acc_data = req_data[32'(acc_idx) * WIDTH +: WIDTH];
    if (accept) begin
      if (acc_last) begin
        state_next  = IDLE;
        rr_ptr_next = (acc_idx == IW'(NREQ - 1)) ? '0 : acc_idx + IW'(1);
      end else begin
        state_next = BURST;
        lock_next  = acc_idx;
      end
    end
  end

  always_comb begin
    count_next = count;
    if (accept && !(pop && !empty))      count_next = count + CWIDTH'(1);
    else if (!accept && pop && !empty)   count_next = count - CWIDTH'(1);
  end

  always_ff @(posedge clk0) begin
    if (!rstn) begin
      fifo_en   <= 1'b0;
      fifo_data <= '0;
      grant_id  <= '0;
      count     <= '0;
      pop_err   <= 1'b0;
    end else begin
      fifo_en <= accept;
      if (accept) begin
        fifo_data <= acc_data;
        grant_id  <= acc_idx;
      end
      count <= count_next;
      if (pop && empty) pop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ehgu_fifo_arb.sv
// Directed bench for ehgu_fifo_arb with a cycle-level reference model.
module tb_ehgu_fifo_arb;

  localparam int N = 4;
  localparam int D = 128;

  logic        clk0 = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last  = '0;
  logic [31:0] req_data  = '0;
  logic        pop       = 1'b0;
  logic [3:0]  req_ready;
  logic        fifo_en;
  logic [7:0]  fifo_data;
  logic [1:0]  grant_id;
  logic [7:0]  count;
  logic        full, empty, pop_err;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: what the outputs must be after the latest edge.
  int m_lock  = -1;
  int m_ptr   = 0;
  int m_count = 0;
  int m_id    = 0;
  int m_data  = 0;
  int m_en    = 0;
  int m_err   = 0;

  int log_code = 0;
  int log_n    = 0;

  ehgu_fifo_arb dut (
    .clk0      (clk0),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .pop       (pop),
    .fifo_en   (fifo_en),
    .fifo_data (fifo_data),
    .grant_id  (grant_id),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .pop_err   (pop_err)
  );

  initial forever #5 clk0 = ~clk0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int model_grant();
    if (!rstn || m_count == D) return -1;
    if (m_lock >= 0) return req_valid[m_lock] ? m_lock : -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  // Compare on the falling edge, then advance the model to the next rising edge.
  always @(negedge clk0) begin
    int g;
    int exp_ready;
    g = model_grant();
    exp_ready = (g >= 0) ? (1 << g) : 0;
    chk("fifo_en",   int'(fifo_en),   m_en);
    chk("grant_id",  int'(grant_id),  m_id);
    chk("fifo_data", int'(fifo_data), m_data);
    chk("count",     int'(count),     m_count);
    chk("full",      int'(full),      (m_count == D) ? 1 : 0);
    chk("empty",     int'(empty),     (m_count == 0) ? 1 : 0);
    chk("pop_err",   int'(pop_err),   m_err);
    chk("ready_grant", int'(req_ready & req_valid), exp_ready);
    chk("ready_onehot0", ($countones(req_ready) <= 1) ? 1 : 0, 1);
    if (fifo_en) begin
      log_code = log_code * 10 + int'(grant_id);
      log_n++;
    end
    if (!rstn) begin
      m_lock = -1; m_ptr = 0; m_count = 0; m_id = 0; m_data = 0; m_en = 0; m_err = 0;
    end else begin
      if (g >= 0) begin
        m_en   = 1;
        m_id   = g;
        m_data = int'(req_data >> (8 * g)) & 255;
        if (req_last[g]) begin
          m_lock = -1;
          m_ptr  = (g + 1) % N;
        end else begin
          m_lock = g;
        end
      end else begin
        m_en = 0;
      end
      if (pop && m_count == 0) m_err = 1;
      m_count = m_count + ((g >= 0) ? 1 : 0) - ((pop && m_count > 0) ? 1 : 0);
    end
  end

  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                      input logic p);
    req_valid = v;
    req_last  = l;
    req_data  = d;
    pop       = p;
    @(posedge clk0);
    #1;
  endtask

  task automatic clear_log();
    log_code = 0;
    log_n    = 0;
  endtask

  initial begin
    step(4'h0, 4'h0, 32'h0, 1'b0);
    step(4'h0, 4'h0, 32'h0, 1'b0);
    rstn = 1'b1;
    chk("reset_count", int'(count), 0);
    chk("reset_fifo_en", int'(fifo_en), 0);

    // All four requesting single beats: strict rotation.
    for (int i = 0; i < 5; i++)
      step(4'hF, 4'hF, 32'h03020100 + 32'h10101010 * 32'(i), 1'b0);
    step(4'h0, 4'h0, 32'h0, 1'b0);
    chk("rotation_n", log_n, 5);
    chk("rotation_ids", log_code, 1230);
    chk("rotation_count", int'(count), 5);

    // Simultaneous accept and pop, drain, then underflow.
    step(4'b1000, 4'b1000, 32'hAB000000, 1'b1);
    chk("acc_pop_count", int'(count), 5);
    repeat (5) step(4'h0, 4'h0, 32'h0, 1'b1);
    chk("drain_count", int'(count), 0);
    chk("no_err_yet", int'(pop_err), 0);
    step(4'h0, 4'h0, 32'h0, 1'b1);
    chk("pop_err_set", int'(pop_err), 1);
    chk("underflow_count", int'(count), 0);
    step(4'h0, 4'h0, 32'h0, 1'b0);
    chk("pop_err_sticky", int'(pop_err), 1);

    // Req1 three-beat burst while req2 waits.
    clear_log();
    step(4'b0110, 4'b0100, 32'h00221100, 1'b0);
    step(4'b0110, 4'b0100, 32'h00221200, 1'b0);
    step(4'b0110, 4'b0110, 32'h00221300, 1'b0);
    step(4'b0100, 4'b0100, 32'h00220000, 1'b0);
    step(4'h0, 4'h0, 32'h0, 1'b0);
    chk("burst_n", log_n, 4);
    chk("burst_ids", log_code, 1112);
    chk("burst_tail_data", int'(fifo_data), 'h22);

    // Locked req2 stalls; req0 must not slip in.
    clear_log();
    step(4'b0100, 4'b0000, 32'h00440000, 1'b0);
    step(4'b0001, 4'b0001, 32'h00000055, 1'b0);
    chk("stall_ready_zero", int'(req_ready), 0);
    repeat (3) step(4'b0001, 4'b0001, 32'h00000055, 1'b0);
    step(4'b0101, 4'b0101, 32'h00450055, 1'b0);
    step(4'b0001, 4'b0001, 32'h00000056, 1'b0);
    step(4'h0, 4'h0, 32'h0, 1'b0);
    chk("stall_n", log_n, 3);
    chk("stall_ids", log_code, 220);

    // Reset in the middle of a req0 burst.
    step(4'b0001, 4'b0000, 32'h00000061, 1'b0);
    rstn = 1'b0;
    #1;
    chk("ready_in_reset", int'(req_ready), 0);
    step(4'b0001, 4'b0000, 32'h00000062, 1'b0);
    rstn = 1'b1;
    chk("midrst_count", int'(count), 0);
    chk("midrst_fifo_en", int'(fifo_en), 0);
    chk("midrst_pop_err", int'(pop_err), 0);
    clear_log();
    step(4'b1110, 4'b1110, 32'h74737271, 1'b0);
    step(4'h0, 4'h0, 32'h0, 1'b0);
    chk("post_rst_n", log_n, 1);
    chk("post_rst_id", log_code, 1);

    // Fill to capacity, then free one slot.
    for (int i = 0; i < 200 && !full; i++)
      step(4'b0010, 4'b0010, 32'h00009900 + 32'(i << 8), 1'b0);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 128);
    chk("fill_ready_zero", int'(req_ready), 0);
    step(4'b0010, 4'b0010, 32'h00000700, 1'b0);
    chk("full_hold_count", int'(count), 128);
    step(4'b0010, 4'b0010, 32'h00000800, 1'b1);
    chk("one_pop_count", int'(count), 127);
    chk("one_pop_ready", int'(req_ready), 'b0010);
    step(4'b0010, 4'b0010, 32'h00000900, 1'b0);
    chk("refill_count", int'(count), 128);
    chk("refill_full", int'(full), 1);
    step(4'h0, 4'h0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
